// File: rtl/fp_result_packer.sv
// fp_result_packer: two-stage round-and-pack back end for a single-precision
// floating-point unit. Stage 1 rounds to nearest even. Stage 2 applies the
// special-case overrides and range checks, then packs the IEEE-754 word.
// Both stages use a valid/ready handshake and stall together under backpressure.
module fp_result_packer #(
    parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [26:0] in_mant,
    input  logic        in_is_nan,
    input  logic        in_is_inf,
    input  logic        in_is_zero,
    input  logic        in_sign_special,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_underflow,
    output logic        out_inexact
);

    // Round to nearest even. The result is {inexact, exponent[9:0], mantissa[23:0]}.
    // A carry out of the 24-bit significand renormalises: shift right, exponent + 1.
    function automatic logic [34:0] round_rne(input logic signed [9:0] e,
                                              input logic [26:0]        m);
        logic               round_up;
        logic               inexact;
        logic        [24:0] sum;
        logic signed [9:0]  e_out;
        logic        [23:0] m_out;
        round_up = m[2] && (m[1] || m[0] || m[3]);
        inexact  = |m[2:0];
        sum      = {1'b0, m[26:3]} + {24'd0, round_up};
        if (sum[24]) begin
            m_out = sum[24:1];
            e_out = e + 10'sd1;
        end else begin
            m_out = sum[23:0];
            e_out = e;
        end
        return {inexact, e_out, m_out};
    endfunction

    // Resolve the final word and flags. The result is {word[31:0], overflow, underflow, inexact}.
    // Priority: NaN > Inf > Zero > Overflow > Underflow > Normal. Denormals are flushed.
    function automatic logic [34:0] pack_result(input logic              nan,
                                                input logic              inf,
                                                input logic              zero,
                                                input logic              sign_special,
                                                input logic              sign,
                                                input logic signed [9:0] e,
                                                input logic [23:0]       m,
                                                input logic              inexact);
        if (nan)
            return {QNAN, 3'b000};
        else if (inf)
            return {sign_special, 8'hFF, 23'h0, 3'b000};
        else if (zero)
            return {sign, 31'h0, 3'b000};
        else if (e >= 10'sd255)
            return {sign, 8'hFF, 23'h0, 3'b101};
        else if (e <= 10'sd0)
            return {sign, 31'h0, 3'b011};
        else
            return {sign, e[7:0], m[22:0], 2'b00, inexact};
    endfunction

    logic               en1;
    logic               en2;
    logic        [34:0] rnd_p0;

    logic               vld_p1;
    logic               sign_p1;
    logic signed [9:0]  exp_p1;
    logic        [23:0] mant_p1;
    logic               inexact_p1;
    logic               nan_p1;
    logic               inf_p1;
    logic               zero_p1;
    logic               sign_special_p1;
    logic        [34:0] pack_p1;

    // A stage advances when its successor is empty or is draining this cycle.
    assign en2      = !out_valid || out_ready;
    assign en1      = !vld_p1 || en2;
    assign in_ready = en1;

    // ---- stage 0 -> stage 1: rounding ----
    assign rnd_p0 = round_rne(in_exp, in_mant);

    // Stage 1 occupancy flag; cleared asynchronously so in-flight beats vanish on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p1 <= 1'b0;
        else if (en1)
            vld_p1 <= in_valid;
    end

    // Stage 1 payload; only meaningful while vld_p1 is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (en1 && in_valid) begin
            sign_p1         <= in_sign;
            inexact_p1      <= rnd_p0[34];
            exp_p1          <= rnd_p0[33:24];
            mant_p1         <= rnd_p0[23:0];
            nan_p1          <= in_is_nan;
            inf_p1          <= in_is_inf;
            zero_p1         <= in_is_zero;
            sign_special_p1 <= in_sign_special;
        end
    end

    // ---- stage 1 -> stage 2: overrides and packing ----
    assign pack_p1 = pack_result(nan_p1, inf_p1, zero_p1, sign_special_p1,
                                 sign_p1, exp_p1, mant_p1, inexact_p1);

    // Output register; holds its value while the downstream block stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_result    <= 32'h0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else if (en2) begin
            out_valid <= vld_p1;
            if (vld_p1)
                {out_result, out_overflow, out_underflow, out_inexact} <= pack_p1;
        end
    end

endmodule

// File: tb/tb_fp_result_packer.sv
// Scoreboard bench for fp_result_packer: expected words are queued on acceptance
// and compared in order as the packer hands beats downstream.
module tb_fp_result_packer;

    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [26:0] mant;
        logic        nan;
        logic        inf;
        logic        zero;
        logic        ss;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [26:0] in_mant;
    logic        in_is_nan;
    logic        in_is_inf;
    logic        in_is_zero;
    logic        in_sign_special;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    logic [34:0] sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_pushed = 0;
    int          n_seen   = 0;
    bit          rand_bp  = 0;

    fp_result_packer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_sign         (in_sign),
        .in_exp          (in_exp),
        .in_mant         (in_mant),
        .in_is_nan       (in_is_nan),
        .in_is_inf       (in_is_inf),
        .in_is_zero      (in_is_zero),
        .in_sign_special (in_sign_special),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_result      (out_result),
        .out_overflow    (out_overflow),
        .out_underflow   (out_underflow),
        .out_inexact     (out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: integer rounding, then the override priority. Returns {word, ovf, unf, inx}.
    function automatic logic [34:0] model(input beat_t b);
        int          e;
        int unsigned m;
        int unsigned rem;
        logic [31:0] eb;
        logic [31:0] mb;
        e   = int'($signed(b.exp));
        m   = int'(b.mant) >> 3;
        rem = int'(b.mant) & 7;
        if (rem > 4 || (rem == 4 && (m % 2) == 1))
            m = m + 1;
        if (m == (1 << 24)) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e == 512)
            e = -512;
        eb = e;
        mb = m;
        if (b.nan)       return {32'h7FC0_0000, 3'b000};
        else if (b.inf)  return {b.ss, 8'hFF, 23'h0, 3'b000};
        else if (b.zero) return {b.sign, 31'h0, 3'b000};
        else if (e >= 255) return {b.sign, 8'hFF, 23'h0, 3'b101};
        else if (e <= 0)   return {b.sign, 31'h0, 3'b011};
        else return {b.sign, eb[7:0], mb[22:0], 2'b00, (rem != 0) ? 1'b1 : 1'b0};
    endfunction

    // Present a beat from just after a rising edge until it is accepted.
    task automatic send(input beat_t b, input logic [34:0] expv, output int waits);
        bit acc;
        acc   = 0;
        waits = 0;
        in_valid        = 1'b1;
        in_sign         = b.sign;
        in_exp          = b.exp;
        in_mant         = b.mant;
        in_is_nan       = b.nan;
        in_is_inf       = b.inf;
        in_is_zero      = b.zero;
        in_sign_special = b.ss;
        while (!acc && waits < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end
        if (acc) begin
            sb_q.push_back(expv);
            n_pushed++;
        end else begin
            check("accept_timeout", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    // Output monitor: every handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_out", {63'd0, out_valid}, 64'd0);
            end else begin
                check("out_beat",
                      {29'd0, out_result, out_overflow, out_underflow, out_inexact},
                      {29'd0, sb_q.pop_front()});
            end
        end
    end

    // Random downstream backpressure when enabled.
    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    beat_t       dir_b[10];
    logic [34:0] dir_e[10];

    initial begin
        int    w;
        beat_t b;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_sign = 1'b0; in_exp = '0; in_mant = '0;
        in_is_nan = 1'b0; in_is_inf = 1'b0; in_is_zero = 1'b0; in_sign_special = 1'b0;

        dir_b[0] = '{1'b0, 10'd127, 27'h400_0000, 1'b0, 1'b0, 1'b0, 1'b0}; dir_e[0] = {32'h3F80_0000, 3'b000};
        dir_b[1] = '{1'b0, 10'd127, 27'h7FF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0}; dir_e[1] = {32'h4000_0000, 3'b001};
        dir_b[2] = '{1'b0, 10'd127, 27'h400_0004, 1'b0, 1'b0, 1'b0, 1'b0}; dir_e[2] = {32'h3F80_0000, 3'b001};
        dir_b[3] = '{1'b0, 10'd254, 27'h7FF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0}; dir_e[3] = {32'h7F80_0000, 3'b101};
        dir_b[4] = '{1'b1, 10'd0,   27'h400_0000, 1'b0, 1'b0, 1'b0, 1'b0}; dir_e[4] = {32'h8000_0000, 3'b011};
        dir_b[5] = '{1'b0, 10'd1,   27'h400_0000, 1'b1, 1'b1, 1'b0, 1'b1}; dir_e[5] = {32'h7FC0_0000, 3'b000};
        dir_b[6] = '{1'b0, 10'd300, 27'h400_0000, 1'b0, 1'b1, 1'b0, 1'b1}; dir_e[6] = {32'hFF80_0000, 3'b000};
        dir_b[7] = '{1'b1, 10'd5,   27'h400_0007, 1'b0, 1'b0, 1'b1, 1'b0}; dir_e[7] = {32'h8000_0000, 3'b000};
        dir_b[8] = '{1'b0, 10'h3FB, 27'h400_0000, 1'b0, 1'b0, 1'b0, 1'b0}; dir_e[8] = {32'h0000_0000, 3'b011};
        dir_b[9] = '{1'b1, 10'd1,   27'h5A5_A5A9, 1'b0, 1'b0, 1'b0, 1'b0}; dir_e[9] = {32'h80B4_B4B5, 3'b001};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_result", {32'd0, out_result}, 64'd0);
        check("rst_flags", {61'd0, out_overflow, out_underflow, out_inexact}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Two-cycle latency of a single beat
        send(dir_b[0], dir_e[0], w);
        @(negedge clk);
        check("lat_cycle1_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("lat_cycle2_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk);
        #1;
        drain();

        // Directed vectors back to back, one beat per cycle
        for (int i = 0; i < 10; i++) begin
            send(dir_b[i], dir_e[i], w);
            check("throughput_stall", 64'(w), 64'd0);
        end
        drain();

        // Backpressure: four beats, out_ready low for three cycles
        out_ready = 1'b0;
        send(dir_b[1], dir_e[1], w);
        send(dir_b[3], dir_e[3], w);
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        check("bp_hold_result", {32'd0, out_result}, {32'd0, dir_e[1][34:3]});
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(dir_b[6], dir_e[6], w);
        send(dir_b[9], dir_e[9], w);
        drain();

        // Random beats under random backpressure
        rand_bp = 1;
        for (int i = 0; i < 60; i++) begin
            b.sign = 1'($urandom_range(0, 1));
            b.exp  = 10'($urandom_range(0, 300) - 20);
            if (i % 15 == 7) b.exp = 10'd511;
            b.mant = {1'b1, 26'($urandom)};
            if (i % 4 == 0) b.mant[2:0] = 3'b100;
            b.nan  = ($urandom_range(0, 9) == 0);
            b.inf  = ($urandom_range(0, 9) == 0);
            b.zero = ($urandom_range(0, 9) == 0);
            b.ss   = 1'($urandom_range(0, 1));
            send(b, model(b), w);
        end
        rand_bp = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();
        check("beat_count", 64'(n_seen), 64'(n_pushed));

        // Reset with both stages full
        out_ready = 1'b0;
        send(dir_b[0], dir_e[0], w);
        send(dir_b[2], dir_e[2], w);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_result", {32'd0, out_result}, 64'd0);
        check("async_rst_flags", {61'd0, out_overflow, out_underflow, out_inexact}, 64'd0);
        n_pushed = n_pushed - sb_q.size();
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_silent", 64'(n_seen), 64'(n_pushed));
        send(dir_b[4], dir_e[4], w);
        drain();
        check("final_count", 64'(n_seen), 64'(n_pushed));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
